// File: rtl/jtframe_z80_romcache.sv
// Two-entry fully associative ROM read cache between the CPU ROM decode and one SDRAM read slot.
// Hits answer combinationally; misses fetch a 32-bit line and hold ok low until it lands.
module jtframe_z80_romcache #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 8,
    localparam int unsigned OB = (DW == 8) ? 2 : 1,
    localparam int unsigned TW = AW - OB
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] dout,
    output logic          ok,
    input  logic          clr,
    output logic [TW-1:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          data_rdy,
    input  logic [31:0]   sdram_data
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e        r_state, w_state_nx;
    logic [1:0]    r_valid;
    logic [TW-1:0] r_tag [2];
    logic [31:0]   r_data [2];
    logic          r_lru;
    logic          r_discard, w_discard_nx;
    logic          r_sdram_req, w_req_nx;
    logic [TW-1:0] r_sdram_addr, w_addr_nx;

    logic [TW-1:0] w_tag;
    logic [OB-1:0] w_off;
    logic          w_hit0, w_hit1, w_hit;
    logic [31:0]   w_line;
    logic          w_done, w_fill;

    assign w_tag  = addr[AW-1:OB];
    assign w_off  = addr[OB-1:0];
    assign w_hit0 = r_valid[0] && (r_tag[0] == w_tag);
    assign w_hit1 = r_valid[1] && (r_tag[1] == w_tag);
    assign w_hit  = w_hit0 || w_hit1;
    assign ok     = cs && w_hit && !clr;

    assign sdram_req  = r_sdram_req;
    assign sdram_addr = r_sdram_addr;

    always_comb begin
        w_line = 32'd0;
        if (w_hit0) begin
            w_line = r_data[0];
        end else if (w_hit1) begin
            w_line = r_data[1];
        end
        dout = '0;
        for (int i = 0; i < 32 / DW; i++) begin
            if (w_off == i[OB-1:0]) begin
                dout = w_line[i*DW +: DW];
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_req_nx   = r_sdram_req;
        w_addr_nx  = r_sdram_addr;
        w_done     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (cs && !w_hit && !clr) begin
                    w_state_nx = StReq;
                    w_req_nx   = 1'b1;
                    w_addr_nx  = w_tag;
                end
            end
            StReq: begin
                if (sdram_ack) begin
                    w_req_nx = 1'b0;
                    if (data_rdy) begin
                        w_state_nx = StIdle;
                        w_done     = 1'b1;
                    end else begin
                        w_state_nx = StWait;
                    end
                end
            end
            StWait: begin
                if (data_rdy) begin
                    w_state_nx = StIdle;
                    w_done     = 1'b1;
                end
            end
            default: w_state_nx = StIdle;
        endcase
        // A clr anywhere during the fill poisons the returning line
        w_fill       = w_done && !r_discard && !clr;
        w_discard_nx = r_discard;
        if (w_done) begin
            w_discard_nx = 1'b0;
        end else if (clr && (r_state != StIdle)) begin
            w_discard_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_sdram_req  <= 1'b0;
            r_sdram_addr <= '0;
            r_discard    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_sdram_req  <= w_req_nx;
            r_sdram_addr <= w_addr_nx;
            r_discard    <= w_discard_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 2'b00;
            r_lru    <= 1'b0;
            r_tag[0] <= '0;
            r_tag[1] <= '0;
            r_data[0] <= 32'd0;
            r_data[1] <= 32'd0;
        end else if (clr) begin
            r_valid <= 2'b00;
            r_lru   <= 1'b0;
        end else if (w_fill) begin
            r_valid[r_lru] <= 1'b1;
            r_tag[r_lru]   <= r_sdram_addr;
            r_data[r_lru]  <= sdram_data;
            r_lru          <= ~r_lru;
        end else if (ok) begin
            r_lru <= w_hit0;
        end
    end

endmodule

// File: tb/tb_jtframe_z80_romcache.sv
// Directed bench for jtframe_z80_romcache: an 8-bit instance for the main scenarios
// and a 16-bit instance for halfword lane selection.
module tb_jtframe_z80_romcache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0, clr = 1'b0, ack = 1'b0, rdy = 1'b0;
    logic [15:0] addr = 16'd0;
    logic [31:0] sdata = 32'd0;
    logic [7:0]  dout;
    logic        ok, req;
    logic [13:0] saddr;

    logic        cs16 = 1'b0, ack16 = 1'b0, rdy16 = 1'b0;
    logic [15:0] addr16 = 16'd0;
    logic [31:0] sdata16 = 32'd0;
    logic [15:0] dout16;
    logic        ok16, req16;
    logic [14:0] saddr16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jtframe_z80_romcache #(.AW(16), .DW(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .addr       (addr),
        .dout       (dout),
        .ok         (ok),
        .clr        (clr),
        .sdram_addr (saddr),
        .sdram_req  (req),
        .sdram_ack  (ack),
        .data_rdy   (rdy),
        .sdram_data (sdata)
    );

    jtframe_z80_romcache #(.AW(16), .DW(16)) u_dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs16),
        .addr       (addr16),
        .dout       (dout16),
        .ok         (ok16),
        .clr        (1'b0),
        .sdram_addr (saddr16),
        .sdram_req  (req16),
        .sdram_ack  (ack16),
        .data_rdy   (rdy16),
        .sdram_data (sdata16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Miss with ack and data_rdy arriving together on the first REQ cycle
    task automatic quick_fill(input logic [15:0] a, input logic [31:0] d, input string tag);
        cs = 1'b1;
        addr = a;
        settle();
        check({tag, "_miss_ok"}, ok, 0);
        next();
        settle();
        check({tag, "_req"}, req, 1);
        ack = 1'b1;
        rdy = 1'b1;
        sdata = d;
        next();
        ack = 1'b0;
        rdy = 1'b0;
        settle();
        check({tag, "_ok"}, ok, 1);
        check({tag, "_req_low"}, req, 0);
    endtask

    initial begin
        #12 rst_n = 1'b1;
        next();
        settle();
        check("rst_ok", ok, 0);
        check("rst_dout", dout, 0);
        check("rst_req", req, 0);
        check("rst_saddr", saddr, 0);
        check("rst_ok16", ok16, 0);

        // Miss timeline: ack 2 cycles after req, data_rdy 3 cycles after ack
        cs = 1'b1;
        addr = 16'h0123;
        settle();
        check("t1_miss_ok", ok, 0);
        next();
        settle();
        check("t1_req", req, 1);
        check("t1_saddr", saddr, 14'h0048);
        next();
        settle();
        check("t1_req_hold", req, 1);
        next();
        ack = 1'b1;
        next();
        ack = 1'b0;
        settle();
        check("t1_req_after_ack", req, 0);
        check("t1_wait_ok", ok, 0);
        next();
        next();
        rdy = 1'b1;
        sdata = 32'hDDCCBBAA;
        settle();
        check("t1_ok_at_rdy", ok, 0);
        next();
        rdy = 1'b0;
        settle();
        check("t1_ok", ok, 1);
        check("t1_dout", dout, 8'hDD);

        // Same line hits with zero latency
        next();
        addr = 16'h0120;
        settle();
        check("t2_ok", ok, 1);
        check("t2_dout0", dout, 8'hAA);
        check("t2_req", req, 0);
        next();
        addr = 16'h0121;
        settle();
        check("t2_dout1", dout, 8'hBB);
        next();
        settle();
        check("t2_req_idle", req, 0);

        // Invalidate, then LRU eviction
        cs = 1'b0;
        clr = 1'b1;
        next();
        clr = 1'b0;
        cs = 1'b1;
        settle();
        check("clr_ok", ok, 0);
        cs = 1'b0;
        next();
        quick_fill(16'h0000, 32'h03020100, "t3a");
        next();
        quick_fill(16'h0100, 32'h13121110, "t3b");
        next();
        addr = 16'h0000;
        settle();
        check("t3_readA_ok", ok, 1);
        next();
        quick_fill(16'h0200, 32'h23222120, "t3c");
        check("t3c_dout", dout, 8'h20);
        next();
        addr = 16'h0001;
        settle();
        check("t3_A_hit", ok, 1);
        check("t3_A_dout", dout, 8'h01);
        next();
        addr = 16'h0101;
        settle();
        check("t3_B_miss", ok, 0);
        next();
        settle();
        check("t3_B_req", req, 1);
        check("t3_B_saddr", saddr, 14'h0040);
        ack = 1'b1;
        rdy = 1'b1;
        sdata = 32'h13121110;
        next();
        ack = 1'b0;
        rdy = 1'b0;
        settle();
        check("t3_B_ok", ok, 1);
        check("t3_B_dout", dout, 8'h11);
        next();

        // clr during WAIT discards the returning line
        addr = 16'h0300;
        settle();
        next();
        settle();
        check("t4_req", req, 1);
        check("t4_saddr", saddr, 14'h00C0);
        ack = 1'b1;
        next();
        ack = 1'b0;
        clr = 1'b1;
        settle();
        check("t4_clr_ok", ok, 0);
        check("t4_req_low", req, 0);
        next();
        clr = 1'b0;
        next();
        settle();
        check("t4_wait_req", req, 0);
        rdy = 1'b1;
        sdata = 32'hAABBCCDD;
        settle();
        check("t4_rdy_ok", ok, 0);
        next();
        rdy = 1'b0;
        settle();
        check("t4_discard_ok", ok, 0);
        check("t4_idle_req", req, 0);
        next();
        settle();
        check("t4_rereq", req, 1);
        check("t4_rereq_saddr", saddr, 14'h00C0);
        ack = 1'b1;
        rdy = 1'b1;
        sdata = 32'h332211EE;
        next();
        ack = 1'b0;
        rdy = 1'b0;
        settle();
        check("t4_ok", ok, 1);
        check("t4_dout", dout, 8'hEE);
        next();

        // cs dropped while waiting: fill still lands, no extra request
        addr = 16'h0404;
        settle();
        next();
        ack = 1'b1;
        next();
        ack = 1'b0;
        cs = 1'b0;
        settle();
        check("t6_wait_ok", ok, 0);
        next();
        rdy = 1'b1;
        sdata = 32'h87654321;
        settle();
        check("t6_rdy_ok", ok, 0);
        next();
        rdy = 1'b0;
        settle();
        check("t6_after_ok", ok, 0);
        check("t6_after_req", req, 0);
        next();
        settle();
        check("t6_no_req", req, 0);
        cs = 1'b1;
        addr = 16'h0405;
        settle();
        check("t6_hit_ok", ok, 1);
        check("t6_hit_dout", dout, 8'h43);
        next();

        // 16-bit data width
        cs16 = 1'b1;
        addr16 = 16'h0011;
        settle();
        check("w16_miss_ok", ok16, 0);
        next();
        settle();
        check("w16_req", req16, 1);
        check("w16_saddr", saddr16, 15'h0008);
        ack16 = 1'b1;
        rdy16 = 1'b1;
        sdata16 = 32'h44332211;
        next();
        ack16 = 1'b0;
        rdy16 = 1'b0;
        settle();
        check("w16_ok", ok16, 1);
        check("w16_dout_hi", dout16, 16'h4433);
        addr16 = 16'h0010;
        settle();
        check("w16_dout_lo", dout16, 16'h2211);
        next();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
